// File: rtl/mux_n_to_1_reg.sv
// mux_n_to_1_reg: registered N-to-1 multiplexer behind a valid/ready handshake.
//
// Handshake (both sides): a beat transfers on a rising edge where valid and
// ready are both high. Valid must not depend on ready. Once the upstream side
// raises inValid, it holds inValid until the beat transfers. The one-entry
// output register makes inReady combinational: the block can accept whenever
// the register is empty or is being drained in the same cycle. This gives
// full throughput with no bubble.
//
// Legal NUM_INPUTS range is 2..16. The select decode compares only against
// existing input indices. When NUM_INPUTS is a power of two, every select
// value is in range, so selError can never set.
module mux_n_to_1_reg #(
    parameter int   DATA_WIDTH = 32,
    parameter int   NUM_INPUTS = 4,
    localparam int  SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] inputData,
    input  logic [SEL_WIDTH-1:0]             select,
    input  logic                             inValid,
    output logic                             inReady,
    output logic [DATA_WIDTH-1:0]            outputData,
    output logic                             outValid,
    input  logic                             outReady,
    output logic                             selError,
    output logic [15:0]                      xferCount
);

    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_sel_error;
    logic [15:0]           r_xfer_count;

    logic [DATA_WIDTH-1:0] w_mux_data;
    logic                  w_sel_in_range;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_consume;

    // Select decode: an out-of-range index yields zero data and no range hit.
    always_comb begin
        w_mux_data     = '0;
        w_sel_in_range = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (select == SEL_WIDTH'(i)) begin
                w_mux_data     = inputData[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_in_range = 1'b1;
            end
        end
    end

    // Handshake qualifiers. Reset blocks intake so nothing is accepted while it is held.
    always_comb begin
        w_in_ready = !reset && (!r_out_valid || outReady);
        w_accept   = inValid && w_in_ready;
        w_consume  = r_out_valid && outReady;
    end

    // Output register, sticky error flag and consume counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_sel_error  <= 1'b0;
            r_xfer_count <= 16'h0000;
        end else begin
            if (w_accept) begin
                r_out_data  <= w_mux_data;
                r_out_valid <= 1'b1;
                if (!w_sel_in_range) begin
                    r_sel_error <= 1'b1;
                end
            end else if (w_consume) begin
                r_out_valid <= 1'b0;
            end
            if (w_consume) begin
                r_xfer_count <= r_xfer_count + 16'd1;
            end
        end
    end

    assign inReady    = w_in_ready;
    assign outputData = r_out_data;
    assign outValid   = r_out_valid;
    assign selError   = r_sel_error;
    assign xferCount  = r_xfer_count;

endmodule

// File: tb/tb_mux_n_to_1_reg.sv
// Directed bench for mux_n_to_1_reg. It drives two instances from the same
// stimulus: one with 4 inputs (power of two) and one with 3 inputs, where
// select=3 is out of range.
module tb_mux_n_to_1_reg;

    localparam int DW = 32;

    // Clock and reset.
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [4*DW-1:0] in_data;
    logic [1:0]      sel;
    logic            in_valid;
    logic            out_ready;

    logic            in_ready4,  out_valid4,  sel_error4;
    logic [DW-1:0]   out_data4;
    logic [15:0]     xfer4;
    logic            in_ready3,  out_valid3,  sel_error3;
    logic [DW-1:0]   out_data3;
    logic [15:0]     xfer3;

    int n_vec = 0;
    int n_err = 0;

    mux_n_to_1_reg #(.DATA_WIDTH(DW), .NUM_INPUTS(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .inputData  (in_data),
        .select     (sel),
        .inValid    (in_valid),
        .inReady    (in_ready4),
        .outputData (out_data4),
        .outValid   (out_valid4),
        .outReady   (out_ready),
        .selError   (sel_error4),
        .xferCount  (xfer4)
    );

    mux_n_to_1_reg #(.DATA_WIDTH(DW), .NUM_INPUTS(3)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .inputData  (in_data[3*DW-1:0]),
        .select     (sel),
        .inValid    (in_valid),
        .inReady    (in_ready3),
        .outputData (out_data3),
        .outValid   (out_valid3),
        .outReady   (out_ready),
        .selError   (sel_error3),
        .xferCount  (xfer3)
    );

    // Driver helpers.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks both instances where they must agree on everything.
    task automatic chk_both(input string tag, input logic [31:0] data, input logic valid,
                            input logic [15:0] cnt);
        chk({tag, " data4"},  out_data4,        data);
        chk({tag, " valid4"}, 32'(out_valid4),  32'(valid));
        chk({tag, " cnt4"},   32'(xfer4),       32'(cnt));
        chk({tag, " data3"},  out_data3,        data);
        chk({tag, " valid3"}, 32'(out_valid3),  32'(valid));
        chk({tag, " cnt3"},   32'(xfer3),       32'(cnt));
    endtask

    // Directed stimulus sequence.
    initial begin
        in_data   = {32'h12345678, 32'hDEADBEEF, 32'h00112233, 32'hAABBCCDD};
        sel       = 2'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        tick();
        // The block must not accept an offer while reset is held.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst inready4", 32'(in_ready4), 32'd0);
        chk("rst inready3", 32'(in_ready3), 32'd0);
        tick();
        chk_both("rst", 32'h0, 1'b0, 16'd0);
        chk("rst selerr3", 32'(sel_error3), 32'd0);

        // Single transfer with select=2.
        reset    = 1'b0;
        in_valid = 1'b0;
        sel      = 2'd2;
        #1;
        chk("post rst inready", 32'(in_ready4), 32'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_both("sel2 load", 32'hDEADBEEF, 1'b1, 16'd0);
        tick();
        chk_both("sel2 drain", 32'hDEADBEEF, 1'b0, 16'd1);

        // Back-to-back transfers with select 0, 1, 3.
        in_valid = 1'b1;
        sel      = 2'd0;
        tick();
        chk_both("b2b sel0", 32'hAABBCCDD, 1'b1, 16'd1);
        chk("b2b inready a", 32'(in_ready4), 32'd1);
        sel = 2'd1;
        tick();
        chk_both("b2b sel1", 32'h00112233, 1'b1, 16'd2);
        chk("b2b inready b", 32'(in_ready4), 32'd1);
        sel = 2'd3;
        tick();
        chk("b2b sel3 data4", out_data4, 32'h12345678);
        chk("b2b sel3 cnt4", 32'(xfer4), 32'd3);
        chk("b2b sel3 selerr4", 32'(sel_error4), 32'd0);
        chk("oob data3", out_data3, 32'h00000000);
        chk("oob valid3", 32'(out_valid3), 32'd1);
        chk("oob selerr3", 32'(sel_error3), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("b2b drain valid4", 32'(out_valid4), 32'd0);
        chk("b2b drain cnt4", 32'(xfer4), 32'd4);
        chk("b2b drain cnt3", 32'(xfer3), 32'd4);

        // Backpressure: load select=1, then stall for three cycles while select changes.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        sel       = 2'd1;
        tick();
        chk_both("bp load", 32'h00112233, 1'b1, 16'd4);
        for (int k = 0; k < 3; k++) begin
            sel = (k == 0) ? 2'd2 : ((k == 1) ? 2'd3 : 2'd0);
            #1;
            chk("bp inready4", 32'(in_ready4), 32'd0);
            chk("bp inready3", 32'(in_ready3), 32'd0);
            tick();
            chk_both("bp hold", 32'h00112233, 1'b1, 16'd4);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk_both("bp release", 32'h00112233, 1'b0, 16'd5);
        tick();
        chk("bp single consume", 32'(xfer4), 32'd5);

        // An in-range transfer does not clear the sticky error flag.
        in_valid = 1'b1;
        sel      = 2'd0;
        tick();
        chk_both("after oob", 32'hAABBCCDD, 1'b1, 16'd5);
        chk("sticky selerr3", 32'(sel_error3), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("after oob drain", 32'(xfer3), 32'd6);

        // Offers with inValid low leave all state unchanged.
        sel       = 2'd3;
        out_ready = 1'b0;
        in_data   = {32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D};
        tick();
        tick();
        chk_both("idle", 32'hAABBCCDD, 1'b0, 16'd6);
        chk("idle selerr3", 32'(sel_error3), 32'd1);
        in_data = {32'h12345678, 32'hDEADBEEF, 32'h00112233, 32'hAABBCCDD};

        // Reset during a stall discards the held result.
        in_valid = 1'b1;
        sel      = 2'd2;
        tick();
        in_valid = 1'b0;
        tick();
        chk_both("stall pre-rst", 32'hDEADBEEF, 1'b1, 16'd6);
        reset = 1'b1;
        tick();
        chk_both("mid-stall rst", 32'h0, 1'b0, 16'd0);
        chk("mid-stall rst selerr3", 32'(sel_error3), 32'd0);
        reset = 1'b0;
        #1;
        chk("after rst inready", 32'(in_ready4), 32'd1);

        // Counter wrap: 65536 edges of streaming yield 65535 consumes, and one more wraps to 0.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        sel       = 2'd0;
        repeat (65536) @(posedge clk);
        #1;
        chk("cnt max4", 32'(xfer4), 32'h0000FFFF);
        chk("cnt max3", 32'(xfer3), 32'h0000FFFF);
        in_valid = 1'b0;
        tick();
        chk_both("cnt wrap", 32'hAABBCCDD, 1'b0, 16'h0000);
        chk("pow2 selerr4 never", 32'(sel_error4), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
